// File: rtl/sram_axi_arbiter_pkg.sv
// sram_axi_arbiter_pkg: shared FSM states, AXI constants and write-strobe helper.
package sram_axi_arbiter_pkg;
  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
  // size 3 is not a legal sram-like size and falls back to a full word
  function automatic logic [3:0] wstrb_of(input logic [1:0] size, input logic [1:0] lane);
    return size >= SZ_WORD ? 4'b1111 : (size == SZ_BYTE ? 4'b0001 : 4'b0011) << lane;
  endfunction
endpackage

// File: rtl/sram_axi_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester after ptr.
module rr_arbiter #(
  parameter int NUM_CH = 2,
  parameter int IW = 1
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  input  logic              enable,
  output logic [NUM_CH-1:0] grant,
  output logic [IW-1:0]     idx
);
  logic [IW-1:0] k;
  always_comb begin
    grant = '0;
    idx = '0;
    k = ptr;
    for (int i = 0; i < NUM_CH; i++) begin
      k = k == IW'(NUM_CH - 1) ? '0 : k + 1'b1;
      if (enable && grant == '0 && req[k]) begin
        grant[k] = 1'b1;
        idx = k;
      end
    end
  end
endmodule

// File: rtl/sram_axi_arbiter.sv
// sram_axi_arbiter: round-robin NUM_CH sram-like channels onto one AXI3 master, one transaction outstanding.
// Define SRAM_AXI_RESP_ERR_EN to add ch_err, flagging a non-OKAY rresp/bresp alongside ch_data_ok.
module sram_axi_arbiter
  import sram_axi_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int ID_W = 4,
  parameter int ADDR_W = 32
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_wr,
  input  logic [2*NUM_CH-1:0]      ch_size,
  input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
  input  logic [32*NUM_CH-1:0]     ch_wdata,
  output logic [NUM_CH-1:0]        ch_addr_ok,
  output logic [NUM_CH-1:0]        ch_data_ok,
  output logic [31:0]              ch_rdata,
  output logic [ID_W-1:0]          arid,
  output logic [ADDR_W-1:0]        araddr,
  output logic [3:0]               arlen,
  output logic [2:0]               arsize,
  output logic [1:0]               arburst,
  output logic                     arvalid,
  input  logic                     arready,
  input  logic [ID_W-1:0]          rid,
  input  logic [31:0]              rdata,
  input  logic [1:0]               rresp,
  input  logic                     rlast,
  input  logic                     rvalid,
  output logic                     rready,
  output logic [ID_W-1:0]          awid,
  output logic [ADDR_W-1:0]        awaddr,
  output logic [3:0]               awlen,
  output logic [2:0]               awsize,
  output logic [1:0]               awburst,
  output logic                     awvalid,
  input  logic                     awready,
  output logic [ID_W-1:0]          wid,
  output logic [31:0]              wdata,
  output logic [3:0]               wstrb,
  output logic                     wlast,
  output logic                     wvalid,
  input  logic                     wready,
  input  logic [ID_W-1:0]          bid,
  input  logic [1:0]               bresp,
  input  logic                     bvalid,
  output logic                     bready
`ifdef SRAM_AXI_RESP_ERR_EN
  ,
  output logic [NUM_CH-1:0]        ch_err
`endif
);
  localparam int IW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  state_t state, nxt;
  logic [IW-1:0] rr_ptr, g_idx, id_q;
  logic [NUM_CH-1:0] grant, data_ok_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0] size_q;
  logic [31:0] wdata_q;
  logic aw_done, w_done, err_q, arb_en, fire, rd_done, b_done;
  logic unused_ids;
  assign unused_ids = ^{rid, bid};
  // no grant in the data_ok cycle, so a new transaction starts the cycle after it
  assign arb_en = rstn && state == IDLE && data_ok_q == '0;
  assign fire = |grant;
  assign rd_done = state == RD_DATA && rvalid && rlast;
  assign b_done = state == WR_RESP && bvalid;
  rr_arbiter #(.NUM_CH(NUM_CH), .IW(IW)) u_arb (
    .req(ch_req), .ptr(rr_ptr), .enable(arb_en), .grant(grant), .idx(g_idx)
  );
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = fire ? (|(grant & ch_wr) ? WR_REQ : RD_ADDR) : IDLE;
      RD_ADDR: nxt = arready ? RD_DATA : RD_ADDR;
      RD_DATA: nxt = rd_done ? IDLE : RD_DATA;
      WR_REQ:  nxt = (aw_done || awready) && (w_done || wready) ? WR_RESP : WR_REQ;
      WR_RESP: nxt = bvalid ? IDLE : WR_RESP;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    ch_addr_ok = grant;
    ch_data_ok = data_ok_q;
    arvalid = state == RD_ADDR;
    rready = state == RD_DATA;
    awvalid = state == WR_REQ && !aw_done;
    wvalid = state == WR_REQ && !w_done;
    bready = state == WR_RESP;
    arid = ID_W'(id_q);
    araddr = addr_q;
    arlen = '0;
    arsize = {1'b0, size_q};
    arburst = arvalid ? AXI_BURST_INCR : 2'b00;
    awid = ID_W'(id_q);
    awaddr = addr_q;
    awlen = '0;
    awsize = {1'b0, size_q};
    awburst = awvalid ? AXI_BURST_INCR : 2'b00;
    wid = ID_W'(id_q);
    wdata = wdata_q;
    wstrb = wvalid ? wstrb_of(size_q, addr_q[1:0]) : 4'b0000;
    wlast = wvalid;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      rr_ptr <= IW'(NUM_CH - 1);
      id_q <= '0;
      addr_q <= '0;
      size_q <= '0;
      wdata_q <= '0;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      data_ok_q <= '0;
      ch_rdata <= '0;
      err_q <= 1'b0;
    end else begin
      data_ok_q <= rd_done || b_done ? NUM_CH'(1) << id_q : '0;
      if (fire) begin
        rr_ptr <= g_idx;
        id_q <= g_idx;
        addr_q <= ch_addr[g_idx*ADDR_W +: ADDR_W];
        size_q <= ch_size[2*g_idx +: 2];
        wdata_q <= ch_wdata[32*g_idx +: 32];
        aw_done <= 1'b0;
        w_done <= 1'b0;
      end
      if (awvalid && awready) aw_done <= 1'b1;
      if (wvalid && wready) w_done <= 1'b1;
      if (rd_done) begin
        ch_rdata <= rdata;
        err_q <= rresp != AXI_RESP_OKAY;
      end
      if (b_done) err_q <= bresp != AXI_RESP_OKAY;
    end
`ifdef SRAM_AXI_RESP_ERR_EN
  assign ch_err = err_q ? data_ok_q : '0;
`else
  logic unused_resp;
  assign unused_resp = ^{err_q, rresp, bresp};
`endif
endmodule

// File: doc/sram_axi_arbiter.md
Name: sram_axi_arbiter

Overview:
- Parametrised successor to the fixed two-port (inst/data) CPU-to-AXI bridge.
- Accepts NUM_CH sram-like request channels (CPU ports, cache refill/writeback, future DMA) and round-robin arbitrates them onto one AXI3 master port.
- One transaction is outstanding at a time; AXI ID carries the channel index.
- Sits between the cache layer and the SoC AXI crossbar.

Parameters:
- NUM_CH, 2, number of sram-like channels (1..8).
- ID_W, 4, AXI ID width; must satisfy 2**ID_W >= NUM_CH.
- ADDR_W, 32, address width. Data width is fixed at 32.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- ch_req  in  NUM_CH  per-channel request.
- ch_wr  in  NUM_CH  1 = write.
- ch_size  in  2*NUM_CH  0 = byte, 1 = half, 2 = word; channel i uses [2i+1:2i].
- ch_addr  in  ADDR_W*NUM_CH  per-channel address.
- ch_wdata  in  32*NUM_CH  per-channel write data.
- ch_addr_ok  out  NUM_CH  request accepted (one-cycle pulse).
- ch_data_ok  out  NUM_CH  response complete (one-cycle pulse).
- ch_rdata  out  32  shared read data; valid while any ch_data_ok bit is high.
- arid/araddr/arlen/arsize/arburst/arvalid  out  ID_W/ADDR_W/4/3/2/1  AR channel.
- arready  in  1.
- rid/rdata/rresp/rlast/rvalid  in  ID_W/32/2/1/1.
- rready  out  1.
- awid/awaddr/awlen/awsize/awburst/awvalid  out  ID_W/ADDR_W/4/3/2/1  AW channel.
- awready  in  1.
- wid/wdata/wstrb/wlast/wvalid  out  ID_W/32/4/1/1.
- wready  in  1.
- bid/bresp/bvalid  in  ID_W/2/1.
- bready  out  1.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, rr_ptr = NUM_CH-1 so channel 0 wins first. Reset asserted mid-transaction aborts it immediately; no data_ok is issued.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP.
- IDLE, any ch_req high:
  - Grant the first requester after rr_ptr (wrapping).
  - Pulse ch_addr_ok[g] for that cycle only.
  - Latch addr, size, wr and wdata; set rr_ptr = g.
  - Next state is WR_REQ if wr, otherwise RD_ADDR.
  - A channel whose req drops before grant is not served.
- RD_ADDR:
  - arvalid = 1, araddr = latched addr, arid = g, arlen = 0, arsize = {0,size}, arburst = 2'b01.
  - Hold all fields stable until arready, then go to RD_DATA.
- RD_DATA:
  - rready = 1.
  - On rvalid & rlast: register rdata into ch_rdata, pulse ch_data_ok[g] the following cycle, return to IDLE.
  - rid mismatch is ignored; there is a single outstanding transaction.
- WR_REQ:
  - awvalid and wvalid are raised together; wlast = 1, awlen = 0.
  - Separate aw_done and w_done flags record each handshake; each valid drops after its own handshake.
  - Handshakes may complete in either order or the same cycle. Go to WR_RESP when both are done.
- wstrb:
  - size 0: 4'b0001 << addr[1:0].
  - size 1: 4'b0011 << addr[1:0] (addr[0] must be 0).
  - size 2: 4'b1111.
  - size 3 is treated as size 2.
- wdata is passed unshifted; the caller supplies lane-aligned data.
- WR_RESP: bready = 1. On bvalid, pulse ch_data_ok[g] and return to IDLE.
- Back-to-back: the earliest new grant is the cycle after data_ok.
- Only one ch_addr_ok and one ch_data_ok bit may be high in any cycle.
- Fairness: with all channels requesting continuously, grants rotate 0,1,..,NUM_CH-1,0.

Optional Feature:
- Macro: SRAM_AXI_RESP_ERR_EN.
- When defined: adds output ch_err (NUM_CH). ch_err[g] pulses with ch_data_ok[g] when the captured rresp or bresp is non-zero (SLVERR/DECERR).
- When undefined: the port is absent and resp fields are ignored.

Decomposition:
- Shared package holds:
  - FSM state typedef.
  - AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00.
  - Size encodings SZ_BYTE/SZ_HALF/SZ_WORD.
  - The wstrb function.
- Sub-module rr_arbiter (NUM_CH): inputs req, ptr, enable; outputs one-hot grant and encoded index. Combinational, with the pointer register held in the parent.

Test Plan:
- Single read: ch0 read 0x1FC00000 size 2, arready after 2 cycles, rdata 0xDEADBEEF -> araddr 0x1FC00000, arid 0, arsize 2; ch_data_ok[0] pulses once; ch_rdata = 0xDEADBEEF.
- Byte write: ch1 write addr 0x80000003 size 0, wdata 0xAA000000; wready before awready -> wstrb 4'b1000, awid 1; data_ok[1] only after bvalid.
- Fairness: NUM_CH=3, all channels request continuously for 6 transactions -> grant order 0,1,2,0,1,2; never two addr_ok bits in one cycle.
- Simultaneous handshakes: awready and wready both high in the cycle the valids rise -> both valids drop the next cycle; exactly one B wait.
- Reset mid-read: drop rstn while in RD_DATA -> rready/arvalid go 0 asynchronously, no data_ok; after release ch0 wins first.
- With SRAM_AXI_RESP_ERR_EN, bresp = 2'b10 on a ch0 write -> ch_err[0] and ch_data_ok[0] pulse in the same cycle.
